spi_cfg_sequencer: RTL and testbench
====================================

// Module: spi_cfg_sequencer
// PURPOSE
//  Power-up configuration engine for the board's SPI front-end devices (ADC/DAC/PLL).
//  Sits directly downstream of the board power-on timer and holds off while por_done is low.
//  After release and a programmable settle delay, it reads NUM_WORDS configuration words from an external registered ROM.
//  It shifts each word out over SPI mode 0, MSB first, then asserts cfg_done to enable the acquisition datapath.
// PARAMETERS
//  CLK_DIV    4    SCLK half-period in clk cycles (>=1); SCLK = f_clk/(2*CLK_DIV)
//  WORD_W     24   bits per SPI frame (addr+data), 8..32
//  NUM_WORDS  16   words in config table (>=1)
//  ADDR_W     4    rom_addr width; 2**ADDR_W >= NUM_WORDS
//  START_DLY  100  clk cycles from por_done rise to first ROM fetch (>=1)
//  GAP_CYC    8    clk cycles cs_n held high between frames (>=1)
// PORTS
//  clk          in   1       system clock
//  user_rst     in   1       synchronous reset, active high
//  por_done     in   1       power-on timer expired (high = supplies stable); low forces abort/hold
//  cfg_restart  in   1       1-cycle pulse: rerun full table; honoured only in DONE
//  rom_addr     out  ADDR_W  config ROM word address
//  rom_data     in   WORD_W  ROM read data, valid 2 clk after rom_addr changes
//  spi_sclk     out  1       SPI clock, idle low
//  spi_cs_n     out  1       SPI chip select, active low, idle high
//  spi_mosi     out  1       SPI data out, idle low
//  cfg_busy     out  1       high from leaving IDLE until DONE entered
//  cfg_done     out  1       high while table fully written (DONE state)
// BEHAVIOUR
//  Reset (user_rst=1 at clk edge): state=IDLE.
//   Outputs: spi_sclk=0, spi_cs_n=1, spi_mosi=0, rom_addr=0, cfg_busy=0, cfg_done=0.
//   Clears all counters. user_rst has priority over every other input.
//  States: IDLE -> WAIT_DLY -> FETCH -> SHIFT -> GAP -> (FETCH | DONE).
//  IDLE: waits for por_done=1. Next cycle enters WAIT_DLY with delay counter at 0.
//  WAIT_DLY: counts START_DLY cycles, then enters FETCH with rom_addr=0.
//  FETCH: lasts exactly 2 cycles. Registers rom_addr, then loads rom_data into the shift register on the 2nd cycle.
//   On exit: spi_cs_n=0, spi_mosi=word[WORD_W-1].
//  SHIFT: cs_n setup of CLK_DIV cycles with sclk=0, then 2*WORD_W half-periods of CLK_DIV cycles each.
//   sclk rises on odd half-periods, where the slave samples.
//   On each falling edge, except the last, mosi advances to the next lower bit.
//   spi_cs_n is low for exactly (2*WORD_W+1)*CLK_DIV cycles per frame.
//   On exit: spi_cs_n=1, spi_sclk=0, spi_mosi=0.
//  GAP: holds cs_n high for GAP_CYC cycles.
//   If word index == NUM_WORDS-1, enters DONE; otherwise increments rom_addr and enters FETCH.
//  DONE: cfg_done=1, cfg_busy=0, outputs idle, rom_addr holds last value.
//   A cfg_restart pulse sets rom_addr=0 and enters FETCH directly; START_DLY is skipped.
//  cfg_restart outside DONE: ignored, not queued.
//  por_done low in any non-IDLE state: next cycle state=IDLE with all outputs at reset values.
//   Any frame in progress is truncated (cs_n rises immediately); the full sequence reruns on the next por_done rise.
//  por_done and cfg_restart together in DONE: the por_done=0 abort wins.
//  NUM_WORDS=1: a single frame, then GAP, then DONE.
//  rom_addr never exceeds NUM_WORDS-1. Counters saturate or clear; no wrap is visible at outputs.
//  All outputs are registered, with no combinational path from inputs to outputs.
// TESTING
//  (Bench params: CLK_DIV=2, WORD_W=24, NUM_WORDS=3, START_DLY=10, GAP_CYC=4. ROM = {0x8A5F01, 0x000000, 0xFFFFFF}.)
//  T1 reset: user_rst high 3 cycles with por_done=1 -> cs_n=1, sclk=0, mosi=0, busy=0, done=0, rom_addr=0.
//  T2 startup: por_done rises at cycle t -> first cs_n fall at t+1+10+2.
//   Each frame: cs_n low exactly 98 cycles with 24 sclk rising edges.
//   Slave-model bits sampled on sclk rise = 0x8A5F01, 0x000000, 0xFFFFFF in order.
//   Then cfg_done=1 after the last GAP.
//  T3 gap/timing: between frames cs_n high exactly 4 + 2 = 6 cycles (GAP + FETCH). sclk low whenever cs_n high.
//  T4 abort: drop por_done during bit 10 of frame 1 -> next cycle cs_n=1, busy=0.
//   Re-raise por_done -> sequence restarts from rom_addr=0 with the full START_DLY, and all 3 frames are resent.
//  T5 restart: cfg_restart pulse in DONE -> busy=1 next cycle and 3 frames resent without START_DLY.
//   A pulse mid-sequence is ignored: frame count is still 3 and cfg_done is asserted once.
//  T6 simultaneous: in DONE, por_done=0 in the same cycle as cfg_restart=1 -> IDLE, no frame emitted.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// Purpose : power-up engine that streams NUM_WORDS ROM words out over SPI mode 0, MSB first, then flags cfg_done.
// Latency : first cs_n fall 1+START_DLY+2 clk after por_done is seen; each frame holds cs_n low (2*WORD_W+1)*CLK_DIV clk.
// Backpressure: none; the ROM has a fixed 2-clk read latency and por_done low aborts to IDLE on the next edge.
module spi_cfg_sequencer #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_W    = 24,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4,
    parameter int START_DLY = 100,
    parameter int GAP_CYC   = 8
) (
    input  logic              clk_i,
    input  logic              user_rst_i,
    input  logic              por_done_i,
    input  logic              cfg_restart_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [WORD_W-1:0] rom_data_i,
    output logic              spi_sclk_o,
    output logic              spi_cs_n_o,
    output logic              spi_mosi_o,
    output logic              cfg_busy_o,
    output logic              cfg_done_o
);

    // Half-period index: 0 is the cs_n setup phase, 1..2*WORD_W are the clocked half-periods.
    localparam int                HP_W      = $clog2(2 * WORD_W + 1);
    localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(2 * WORD_W);
    localparam logic [HP_W-1:0]   HP_PENULT = HP_W'(2 * WORD_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [31:0]       DLY_LAST  = 32'(START_DLY - 1);
    localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [31:0]       DIV_LAST  = 32'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DLY,
        S_FETCH,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [31:0]         cnt_q;      // shared: settle delay, fetch phase, clock divider, gap
    logic [HP_W-1:0]     hp_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic                mosi_q;
    logic                busy_q;
    logic                done_q;

    // Sequencer FSM with every output registered; reset and por_done abort share one path.
    always_ff @(posedge clk_i) begin
        if (user_rst_i || (state_q != S_IDLE && !por_done_i)) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hp_q       <= '0;
            shreg_q    <= '0;
            rom_addr_q <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (por_done_i) begin
                        state_q <= S_WAIT_DLY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_WAIT_DLY: begin
                    if (cnt_q == DLY_LAST) begin
                        state_q    <= S_FETCH;
                        cnt_q      <= '0;
                        rom_addr_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                // Two cycles: address settles into the ROM, then its registered data is captured.
                S_FETCH: begin
                    if (cnt_q == 32'd1) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        hp_q    <= '0;
                        shreg_q <= rom_data_i;
                        mosi_q  <= rom_data_i[WORD_W-1];
                        cs_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                S_SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (hp_q == HP_LAST) begin
                            state_q <= S_GAP;
                            cs_n_q  <= 1'b1;
                            sclk_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                        end else begin
                            hp_q   <= hp_q + HP_W'(1);
                            // Entering an odd half-period raises sclk; entering an even one drops it.
                            sclk_q <= ~hp_q[0];
                            // Falling edge: present the next bit, except after the final bit.
                            if (hp_q[0] && hp_q != HP_PENULT) begin
                                shreg_q <= shreg_q << 1;
                                mosi_q  <= shreg_q[WORD_W-2];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (rom_addr_q == ADDR_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= rom_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                // Restart skips the settle delay: supplies are already known good.
                S_DONE: begin
                    if (cfg_restart_i) begin
                        state_q    <= S_FETCH;
                        cnt_q      <= '0;
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign spi_sclk_o = sclk_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_mosi_o = mosi_q;
    assign cfg_busy_o = busy_q;
    assign cfg_done_o = done_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Purpose : randomized scoreboard bench; an SPI slave monitor checks each frame against a table-driven model.
// Latency : start and restart latencies are measured directly in the stimulus thread.
// Backpressure: none; all waits are bounded by cycle budgets.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int WORD_W      = 24;
    localparam int NUM_WORDS   = 3;
    localparam int ADDR_W      = 2;
    localparam int START_DLY   = 10;
    localparam int GAP_CYC     = 4;
    localparam int FRAME_CS    = (2 * WORD_W + 1) * CLK_DIV;  // 98
    localparam int GAP_HIGH    = GAP_CYC + 2;                 // gap plus fetch
    localparam int START_LAT   = 1 + START_DLY + 2;           // 13
    localparam int RESTART_LAT = 1 + 2;                       // 3

    typedef struct {
        logic [WORD_W-1:0] word;
        bit                chk_gap;
    } exp_t;

    logic              clk;
    logic              user_rst;
    logic              por_done;
    logic              cfg_restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              cfg_busy;
    logic              cfg_done;

    logic [WORD_W-1:0] rom [0:3];

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   frames_done = 0;
    int   cur_bits = 0;
    int   cs_len = 0;
    int   high_len = 1000;
    int   last_gap = 0;
    int   sclk_viol = 0;
    int   addr_viol = 0;
    int   done_rises = 0;
    int   exp_done = 0;
    bit   discard_one = 0;
    bit   prev_cs = 1;
    bit   prev_sclk = 0;
    bit   prev_done = 0;
    logic [WORD_W-1:0] cur_word = '0;

    spi_cfg_sequencer #(
        .CLK_DIV  (CLK_DIV),
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W),
        .START_DLY(START_DLY),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk_i        (clk),
        .user_rst_i   (user_rst),
        .por_done_i   (por_done),
        .cfg_restart_i(cfg_restart),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .spi_sclk_o   (spi_sclk),
        .spi_cs_n_o   (spi_cs_n),
        .spi_mosi_o   (spi_mosi),
        .cfg_busy_o   (cfg_busy),
        .cfg_done_o   (cfg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered ROM: data for an address change is sampled by the DUT two edges later.
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #800us;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a full run emits every table word in address order.
    task automatic push_run();
        for (int i = 0; i < NUM_WORDS; i++) begin
            exp_t e;
            e.word    = rom[i];
            e.chk_gap = (i != 0);
            exp_q.push_back(e);
        end
    endtask

    // SPI slave model and scoreboard checker, sampling on the falling clk edge.
    always @(negedge clk) begin
        exp_t e;
        if (spi_cs_n === 1'b0) begin
            if (prev_cs) begin
                cs_len   = 0;
                cur_bits = 0;
                cur_word = '0;
                last_gap = high_len;
            end
            cs_len++;
            if (spi_sclk === 1'b1 && !prev_sclk) begin
                cur_word = {cur_word[WORD_W-2:0], spi_mosi};
                cur_bits++;
            end
        end else begin
            if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) sclk_viol++;
            if (!prev_cs) begin
                high_len = 1;
                if (discard_one) begin
                    discard_one = 0;
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    frames_done++;
                    $display("FAIL unexpected_frame: got word 0x%0h expected no frame at %0t", cur_word, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_word", 32'(cur_word), 32'(e.word));
                    chk("frame_sclk_rises", cur_bits, WORD_W);
                    chk("cs_low_cycles", cs_len, FRAME_CS);
                    if (e.chk_gap) chk("gap_cycles", last_gap, GAP_HIGH);
                    frames_done++;
                end
            end else begin
                high_len++;
            end
        end
        if (rom_addr !== 'x && int'(rom_addr) > NUM_WORDS - 1) addr_viol++;
        if (cfg_done === 1'b1 && !prev_done) done_rises++;
        prev_cs   = (spi_cs_n !== 1'b0);
        prev_sclk = (spi_sclk === 1'b1);
        prev_done = (cfg_done === 1'b1);
    end

    task automatic start_run();
        int n;
        @(posedge clk); #1;
        por_done = 1'b1;
        push_run();
        n = 0;
        while (spi_cs_n !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_latency", n, START_LAT);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (cfg_done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", cfg_done, 1);
        chk("busy_in_done", cfg_busy, 0);
        chk("all_frames_seen", exp_q.size(), 0);
        exp_done++;
        @(negedge clk); #1;
        chk("done_rise_count", done_rises, exp_done);
    endtask

    task automatic abort_at(input int f, input int b, input int base);
        int n;
        n = 0;
        while (!(frames_done == base + f && cur_bits == b && spi_cs_n === 1'b0) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_point_reached", n < 3000, 1);
        por_done    = 1'b0;
        exp_q.delete();
        discard_one = 1;
        @(posedge clk); #1;
        chk("abort_cs_n", spi_cs_n, 1);
        chk("abort_busy", cfg_busy, 0);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_done", cfg_done, 0);
        chk("abort_rom_addr", rom_addr, 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        por_done = 1'b0;
        @(posedge clk); #1;
        chk("idle_done_low", cfg_done, 0);
    endtask

    initial begin
        int base;
        int n;
        logic [WORD_W-1:0] w0, w1, w2;
        w0 = 24'h8A5F01;
        w1 = 24'h000000;
        w2 = 24'hFFFFFF;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = 24'h123456;
        user_rst    = 1'b1;
        por_done    = 1'b1;
        cfg_restart = 1'b0;

        // Reset wins over a high por_done.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_rom_addr", rom_addr, 0);
        user_rst = 1'b0;
        por_done = 1'b0;
        repeat (2) @(posedge clk);

        // Fixed-table startup.
        start_run();
        wait_done();
        go_idle();

        // Abort during bit 10 of frame 1, then full rerun with settle delay.
        base = frames_done;
        start_run();
        abort_at(1, 10, base);
        start_run();
        wait_done();

        // Restart from DONE skips the settle delay; a mid-run pulse is ignored.
        base = frames_done;
        @(posedge clk); #1;
        cfg_restart = 1'b1;
        push_run();
        @(posedge clk); #1;
        cfg_restart = 1'b0;
        chk("restart_busy", cfg_busy, 1);
        chk("restart_done_low", cfg_done, 0);
        n = 1;
        while (spi_cs_n !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart_latency", n, RESTART_LAT);
        repeat ($urandom_range(5, 250)) @(posedge clk);
        #1;
        cfg_restart = 1'b1;
        @(posedge clk); #1;
        cfg_restart = 1'b0;
        wait_done();
        repeat (300) @(posedge clk);
        #1;
        chk("restart_frame_count", frames_done - base, NUM_WORDS);
        chk("restart_done_once", done_rises, exp_done);

        // por_done drop and restart in the same DONE cycle: abort wins.
        base = frames_done;
        @(posedge clk); #1;
        por_done    = 1'b0;
        cfg_restart = 1'b1;
        @(posedge clk); #1;
        cfg_restart = 1'b0;
        chk("simul_done", cfg_done, 0);
        chk("simul_busy", cfg_busy, 0);
        chk("simul_cs_n", spi_cs_n, 1);
        repeat (200) @(posedge clk);
        #1;
        chk("simul_no_frames", frames_done - base, 0);

        // Randomized tables with optional random abort points.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 4; i++) rom[i] = WORD_W'($urandom);
            base = frames_done;
            start_run();
            if ($urandom_range(0, 1) == 1) begin
                abort_at(int'($urandom_range(0, NUM_WORDS - 1)), int'($urandom_range(1, WORD_W - 1)), base);
                start_run();
            end
            wait_done();
            go_idle();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("idle_bus_violations", sclk_viol, 0);
        chk("rom_addr_range", addr_viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("no_pending_discard", discard_one, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
